// File: rtl/memory_access.sv
// MEM pipeline stage: issues loads/stores on a valid/ok data bus, aligns load data, drives mem_wb.
// Build option: MEM_MISALIGN_CHECK_EN completes misaligned accesses locally with a misalign flag.
package memory_access_pkg;
  localparam int unsigned XLEN = 64;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [XLEN-1:0] addr_t;

  typedef struct packed {
    logic        inst_signal;
    logic [31:0] inst;
    addr_t       inst_pc;
    logic [4:0]  reg_dest_addr;
    logic        reg_write_enable;
    word_t       alu_result;
    word_t       store_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
  } ex_mem_t;

  typedef struct packed {
    logic        inst_signal;
    logic [31:0] inst;
    addr_t       inst_pc;
    logic [4:0]  reg_dest_addr;
    logic        reg_write_enable;
    word_t       reg_write_data;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign;
`endif
  } mem_wb_t;
endpackage

module memory_access #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  memory_access_pkg::ex_mem_t  ex_mem_state,
  output memory_access_pkg::mem_wb_t  mem_wb_state,
  output logic                        mem_busy,
  output logic                        dreq_valid,
  output logic [XLEN-1:0]             dreq_addr,
  output logic [2:0]                  dreq_size,
  output logic [7:0]                  dreq_strobe,
  output logic [XLEN-1:0]             dreq_data,
  input  logic                        dresp_addr_ok,
  input  logic                        dresp_data_ok,
  input  logic [XLEN-1:0]             dresp_data
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]  state, state_d;
  logic [31:0] tmo_cnt;

  logic [31:0]               req_inst;
  memory_access_pkg::addr_t  req_pc;
  logic [4:0]                req_rd;
  memory_access_pkg::addr_t  req_addr;
  memory_access_pkg::word_t  req_wdata;
  logic                      req_read;
  logic                      req_write;
  logic [2:0]                req_funct3;

  memory_access_pkg::mem_wb_t mem_wb_d;
  memory_access_pkg::word_t   load_shifted, load_data;
  logic [7:0]                 byte_mask;

  logic in_mem, in_misalign, issue, bus_done, tmo_hit, done;

  assign in_mem = ex_mem_state.inst_signal & (ex_mem_state.mem_read | ex_mem_state.mem_write);

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    in_misalign = 1'b0;
    case (ex_mem_state.funct3[1:0])
      2'd1:    in_misalign = ex_mem_state.alu_result[0];
      2'd2:    in_misalign = |ex_mem_state.alu_result[1:0];
      2'd3:    in_misalign = |ex_mem_state.alu_result[2:0];
      default: in_misalign = 1'b0;
    endcase
  end
`else
  assign in_misalign = 1'b0;
`endif

  assign issue    = (state == IDLE) && in_mem && !in_misalign;
  assign bus_done = ((state == REQ) && dresp_addr_ok && dresp_data_ok) ||
                    ((state == WAIT) && dresp_data_ok);
  assign tmo_hit  = (BUS_TIMEOUT != 0) && (state != IDLE) && (tmo_cnt == BUS_TIMEOUT - 1);
  assign done     = bus_done || tmo_hit;

  // Busy covers the issue cycle too, so EX holds the instruction until its completion cycle.
  assign mem_busy = (state == IDLE) ? issue : !done;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (issue) state_d = REQ;
      REQ:     if (done) state_d = IDLE; else if (dresp_addr_ok) state_d = WAIT;
      WAIT:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dreq_valid = (state == REQ);
  assign dreq_addr  = req_addr;
  assign dreq_size  = {1'b0, req_funct3[1:0]};
  assign dreq_data  = req_wdata << {req_addr[2:0], 3'b000};

  always_comb begin
    case (req_funct3[1:0])
      2'd0:    byte_mask = 8'h01;
      2'd1:    byte_mask = 8'h03;
      2'd2:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  end

  // 8-bit shift context drops lanes that would fall past byte 7.
  assign dreq_strobe = req_write ? (byte_mask << req_addr[2:0]) : 8'h00;

  assign load_shifted = dresp_data >> {req_addr[2:0], 3'b000};

  always_comb begin
    case (req_funct3)
      3'b000:  load_data = {{56{load_shifted[7]}},  load_shifted[7:0]};
      3'b001:  load_data = {{48{load_shifted[15]}}, load_shifted[15:0]};
      3'b010:  load_data = {{32{load_shifted[31]}}, load_shifted[31:0]};
      3'b100:  load_data = {56'd0, load_shifted[7:0]};
      3'b101:  load_data = {48'd0, load_shifted[15:0]};
      3'b110:  load_data = {32'd0, load_shifted[31:0]};
      default: load_data = load_shifted;
    endcase
  end

  always_comb begin
    mem_wb_d = '0;
    if (state == IDLE) begin
      if (ex_mem_state.inst_signal && !in_mem) begin
        mem_wb_d.inst_signal      = 1'b1;
        mem_wb_d.inst             = ex_mem_state.inst;
        mem_wb_d.inst_pc          = ex_mem_state.inst_pc;
        mem_wb_d.reg_dest_addr    = ex_mem_state.reg_dest_addr;
        mem_wb_d.reg_write_enable = ex_mem_state.reg_write_enable;
        mem_wb_d.reg_write_data   = ex_mem_state.alu_result;
      end
`ifdef MEM_MISALIGN_CHECK_EN
      else if (in_mem && in_misalign) begin
        mem_wb_d.inst_signal   = 1'b1;
        mem_wb_d.inst          = ex_mem_state.inst;
        mem_wb_d.inst_pc       = ex_mem_state.inst_pc;
        mem_wb_d.reg_dest_addr = ex_mem_state.reg_dest_addr;
        mem_wb_d.misalign      = 1'b1;
      end
`endif
    end else if (done) begin
      mem_wb_d.inst_signal      = 1'b1;
      mem_wb_d.inst             = req_inst;
      mem_wb_d.inst_pc          = req_pc;
      mem_wb_d.reg_dest_addr    = req_rd;
      mem_wb_d.reg_write_enable = bus_done && req_read && (req_rd != 5'd0);
      mem_wb_d.reg_write_data   = load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mem_wb_state <= '0;
      tmo_cnt      <= '0;
      req_inst     <= '0;
      req_pc       <= '0;
      req_rd       <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_read     <= 1'b0;
      req_write    <= 1'b0;
      req_funct3   <= '0;
    end else begin
      state        <= state_d;
      mem_wb_state <= mem_wb_d;
      tmo_cnt      <= ((state == IDLE) || done) ? '0 : tmo_cnt + 32'd1;
      if (issue) begin
        req_inst   <= ex_mem_state.inst;
        req_pc     <= ex_mem_state.inst_pc;
        req_rd     <= ex_mem_state.reg_dest_addr;
        req_addr   <= ex_mem_state.alu_result;
        req_wdata  <= ex_mem_state.store_data;
        req_read   <= ex_mem_state.mem_read;
        req_write  <= ex_mem_state.mem_write;
        req_funct3 <= ex_mem_state.funct3;
      end
    end
  end
endmodule
